// File: rtl/tx_route_logic_if.sv
// Router output-stage bundle: FIFO pop side, five two-phase tx channels and status.
// master = the tx stage itself, slave = FIFO, neighbours and observers.
interface tx_route_logic_if #(
   parameter int unsigned SIZE = 8
);
   logic                fifo_empty;
   logic                fifo_read;
   logic [SIZE-1:0]     fifo_data_out;
   logic [4:0]          tx_req;
   logic [4:0]          tx_ack;
   logic [SIZE*5-1:0]   tx_data;
   logic                drop_pulse;
   logic [15:0]         sent_count;

   modport master (
      input  fifo_empty, fifo_data_out, tx_ack,
      output fifo_read, tx_req, tx_data, drop_pulse, sent_count
   );

   modport slave (
      output fifo_empty, fifo_data_out, tx_ack,
      input  fifo_read, tx_req, tx_data, drop_pulse, sent_count
   );
endinterface

// File: rtl/tx_route_logic.sv
// Router output stage: pops one flit at a time, XY-routes it by destination id and
// launches it on a two-phase req/ack channel (0 local, 1 N, 2 S, 3 E, 4 W).
// Flits with an out-of-mesh destination are discarded with a one-cycle drop pulse.
module tx_route_logic #(
   parameter int unsigned SIZE   = 8,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned COLS   = 4,
   parameter int unsigned ROWS   = 4,
   parameter int unsigned id     = 0
) (
   input  logic             clk,
   input  logic             reset,
   tx_route_logic_if.master bus
);

   localparam int unsigned NODES = ROWS * COLS;
   localparam int unsigned MY_X  = id % COLS;
   localparam int unsigned MY_Y  = id / COLS;

   localparam logic [2:0] PORT_LOCAL = 3'd0;
   localparam logic [2:0] PORT_NORTH = 3'd1;
   localparam logic [2:0] PORT_SOUTH = 3'd2;
   localparam logic [2:0] PORT_EAST  = 3'd3;
   localparam logic [2:0] PORT_WEST  = 3'd4;

   logic                fetch_pending_q, fetch_pending_d;
   logic                hold_valid_q, hold_valid_d;
   logic [SIZE-1:0]     hold_q, hold_d;
   logic [4:0]          tx_req_q, tx_req_d;
   logic [SIZE*5-1:0]   tx_data_q, tx_data_d;
   logic                drop_pulse_q, drop_pulse_d;
   logic [15:0]         sent_count_q, sent_count_d;

   int unsigned         dest_id, dest_x, dest_y;
   logic                route_legal;
   logic [2:0]          route_port;
   logic                target_idle;
   logic                launch, drop, fifo_read;

   // XY route of the held flit: X is resolved first, then Y, then local delivery.
   always_comb begin
      dest_id               = '0;
      dest_id[ADDR_W-1:0]   = hold_q[ADDR_W-1:0];
      dest_x                = dest_id % COLS;
      dest_y                = dest_id / COLS;
      route_legal           = (dest_id < NODES);
      route_port            = PORT_LOCAL;
      if (dest_x > MY_X)      route_port = PORT_EAST;
      else if (dest_x < MY_X) route_port = PORT_WEST;
      else if (dest_y > MY_Y) route_port = PORT_SOUTH;
      else if (dest_y < MY_Y) route_port = PORT_NORTH;
   end

   // Launch/drop decision and the pop strobe; a pop may overlap the cycle that frees hold.
   always_comb begin
      target_idle = (tx_req_q[route_port] == bus.tx_ack[route_port]);
      launch      = hold_valid_q && route_legal && target_idle;
      drop        = hold_valid_q && !route_legal;
      fifo_read   = !reset && !bus.fifo_empty && !fetch_pending_q &&
                    (!hold_valid_q || launch || drop);
   end

   // Next state: fetched data lands one cycle after the pop, launches toggle one req bit.
   always_comb begin
      fetch_pending_d = fifo_read;
      hold_valid_d    = hold_valid_q;
      hold_d          = hold_q;
      tx_req_d        = tx_req_q;
      tx_data_d       = tx_data_q;
      sent_count_d    = sent_count_q;
      drop_pulse_d    = drop;
      if (launch || drop) hold_valid_d = 1'b0;
      // The committed pop is taken even if fifo_empty has risen since.
      if (fetch_pending_q) begin
         hold_valid_d = 1'b1;
         hold_d       = bus.fifo_data_out;
      end
      if (launch) sent_count_d = sent_count_q + 16'd1;
      for (int k = 0; k < 5; k++) begin
         if (launch && route_port == 3'(k)) begin
            tx_req_d[k]               = ~tx_req_q[k];
            tx_data_d[SIZE*k +: SIZE] = hold_q;
         end
      end
   end

   // State registers; reset discards any held or in-flight flit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pending_q <= 1'b0;
         hold_valid_q    <= 1'b0;
         hold_q          <= '0;
         tx_req_q        <= '0;
         tx_data_q       <= '0;
         drop_pulse_q    <= 1'b0;
         sent_count_q    <= '0;
      end else begin
         fetch_pending_q <= fetch_pending_d;
         hold_valid_q    <= hold_valid_d;
         hold_q          <= hold_d;
         tx_req_q        <= tx_req_d;
         tx_data_q       <= tx_data_d;
         drop_pulse_q    <= drop_pulse_d;
         sent_count_q    <= sent_count_d;
      end
   end

   assign bus.fifo_read  = fifo_read;
   assign bus.tx_req     = tx_req_q;
   assign bus.tx_data    = tx_data_q;
   assign bus.drop_pulse = drop_pulse_q;
   assign bus.sent_count = sent_count_q;

endmodule

// File: tb/tb_tx_route_logic.sv
// Bench for tx_route_logic: router id 5 in a 4x4 mesh with a 5-bit destination field
// so that ids 16..31 are out of mesh. A FIFO model, per-port ack responders and a
// scoreboard of (port, data) in input order check every launch and drop.
module tb_tx_route_logic;

   localparam int unsigned SIZE   = 8;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned COLS   = 4;
   localparam int unsigned ROWS   = 4;
   localparam int unsigned ID     = 5;

   typedef struct {
      int         port;
      logic [7:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   tx_route_logic_if #(.SIZE(SIZE)) bus ();

   tx_route_logic #(
      .SIZE   (SIZE),
      .ADDR_W (ADDR_W),
      .COLS   (COLS),
      .ROWS   (ROWS),
      .id     (ID)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail = 0;
   int         cyc = 0;
   logic [7:0] src_q[$];
   exp_t       exp_q[$];
   int         read_cyc_q[$];
   int         toggle_cyc_q[$];
   int         ack_delay[5];
   int         wait_cnt[5];
   int         last_ack_cyc[5];
   logic [7:0] model_data[5];
   logic       stall = 1'b0;
   logic       rand_on = 1'b0;
   logic       rd_seen = 1'b0;
   logic [4:0] prev_req = '0;
   logic       prev_drop = 1'b0;
   int         launches = 0;
   int         drops = 0;
   int         read_count = 0;
   int         last_latency = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Expected XY output port for destination d from router (1,1); -1 means dropped.
   function automatic int exp_port(input int d);
      int dx, dy;
      if (d >= int'(ROWS * COLS)) return -1;
      dx = d % int'(COLS);
      dy = d / int'(COLS);
      if (dx > int'(ID % COLS)) return 3;
      if (dx < int'(ID % COLS)) return 4;
      if (dy > int'(ID / COLS)) return 2;
      if (dy < int'(ID / COLS)) return 1;
      return 0;
   endfunction

   task automatic push(input logic [7:0] f);
      exp_t e;
      logic [7:0] v;
      v      = f;
      e.port = exp_port(int'(v[4:0]));
      e.data = v;
      src_q.push_back(v);
      exp_q.push_back(e);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || src_q.size() != 0) && n < budget) begin
         @(posedge clk);
         n++;
      end
      check("drain_timeout", 64'(exp_q.size()), 0);
      repeat (6) @(posedge clk);
   endtask

   task automatic wait_launch(input int target, input int budget);
      int n;
      n = 0;
      while (launches < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("wait_launch_timeout", 64'(launches >= target), 1);
   endtask

   // FIFO model and ack responders, driven just after the active edge.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (!reset) begin
         if (rd_seen) begin
            if (src_q.size() > 0) bus.fifo_data_out = src_q.pop_front();
            else check("pop_while_empty", 1, 0);
         end
         for (int p = 0; p < 5; p++) begin
            if (bus.tx_req[p] !== bus.tx_ack[p]) begin
               if (wait_cnt[p] >= ack_delay[p]) begin
                  bus.tx_ack[p]   = ~bus.tx_ack[p];
                  wait_cnt[p]     = 0;
                  last_ack_cyc[p] = cyc;
               end else begin
                  wait_cnt[p]++;
               end
            end
         end
         if (rand_on) stall = ($urandom_range(0, 3) == 0);
         else         stall = 1'b0;
         bus.fifo_empty = (src_q.size() == 0) || stall;
      end
   end

   // Scoreboard: each req toggle or drop pulse must match the oldest outstanding flit.
   always @(negedge clk) begin
      logic [4:0]  toggled;
      logic [39:0] exp_vec;
      int          p;
      exp_t        e;
      rd_seen = bus.fifo_read;
      if (reset) begin
         prev_req  = '0;
         prev_drop = 1'b0;
      end else begin
         if (bus.fifo_read) begin
            read_count++;
            read_cyc_q.push_back(cyc);
         end
         toggled = bus.tx_req ^ prev_req;
         if (toggled != 0) begin
            check("one_req_toggle", 64'($countones(toggled)), 1);
            p = 0;
            for (int k = 4; k >= 0; k--) if (toggled[k]) p = k;
            if (exp_q.size() == 0) begin
               check("unexpected_launch", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("launch_port", 64'(p), 64'(e.port));
               check("launch_data", 64'(bus.tx_data[p*8 +: 8]), 64'(e.data));
               model_data[p] = e.data;
               launches++;
               check("sent_count", 64'(bus.sent_count), 64'(launches & 16'hffff));
               if (read_cyc_q.size() > 0) last_latency = cyc - read_cyc_q.pop_front();
               toggle_cyc_q.push_back(cyc);
            end
         end
         if (bus.drop_pulse) begin
            check("drop_width", 64'(prev_drop), 0);
            if (exp_q.size() == 0) begin
               check("unexpected_drop", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("drop_port", 64'(e.port), 64'(-1));
               drops++;
               if (read_cyc_q.size() > 0) void'(read_cyc_q.pop_front());
            end
         end
         for (int k = 0; k < 5; k++) exp_vec[k*8 +: 8] = model_data[k];
         check("tx_data_stable", 64'(bus.tx_data), 64'(exp_vec));
         prev_req  = bus.tx_req;
         prev_drop = bus.drop_pulse;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1);
   end

   initial begin
      int rc0, tq0, d0;
      bus.fifo_empty    = 1'b1;
      bus.fifo_data_out = '0;
      bus.tx_ack        = '0;
      for (int p = 0; p < 5; p++) begin
         ack_delay[p]  = 0;
         wait_cnt[p]   = 0;
         model_data[p] = '0;
      end

      // Reset state, and no pop while reset is held even with data available.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx_req", 64'(bus.tx_req), 0);
      check("rst_tx_data", 64'(bus.tx_data), 0);
      check("rst_sent_count", 64'(bus.sent_count), 0);
      check("rst_drop_pulse", 64'(bus.drop_pulse), 0);
      check("rst_fifo_read", 64'(bus.fifo_read), 0);
      bus.fifo_empty = 1'b0;
      #1;
      check("rst_fifo_read_nonempty", 64'(bus.fifo_read), 0);
      bus.fifo_empty = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      // Single flit d=7 goes east with 3-cycle latency.
      push(8'h27);
      drain(50);
      check("t2_latency", 64'(last_latency), 3);
      check("t2_tx_req", 64'(bus.tx_req), 64'(5'b01000));
      check("t2_tx_data", 64'(bus.tx_data[31:24]), 64'(8'h27));
      check("t2_sent", 64'(bus.sent_count), 1);

      // d=5,1,13,4 -> local, north, south, west, two cycles apart.
      toggle_cyc_q.delete();
      push(8'h45);
      push(8'h61);
      push(8'h8d);
      push(8'hc4);
      drain(60);
      check("t3_launches", 64'(toggle_cyc_q.size()), 4);
      if (toggle_cyc_q.size() == 4)
         for (int k = 1; k < 4; k++)
            check("t3_gap", 64'(toggle_cyc_q[k] - toggle_cyc_q[k-1]), 2);
      check("t3_tx_req", 64'(bus.tx_req), 64'(5'b11111));
      check("t3_sent", 64'(bus.sent_count), 5);

      // Back-pressure on east: second flit waits for the ack, nothing else is popped.
      ack_delay[3] = 10;
      rc0 = read_count;
      tq0 = toggle_cyc_q.size();
      push(8'h27);
      push(8'h26);
      push(8'h45);
      wait_launch(6, 40);
      repeat (8) @(negedge clk);
      check("t4_reads_blocked", 64'(read_count - rc0), 2);
      check("t4_data_held", 64'(bus.tx_data[31:24]), 64'(8'h27));
      drain(120);
      if (toggle_cyc_q.size() > tq0 + 1)
         check("t4_ack_to_req", 64'(toggle_cyc_q[tq0+1] - last_ack_cyc[3]), 1);
      else
         check("t4_second_launch", 64'(toggle_cyc_q.size()), 64'(tq0 + 2));
      check("t4_sent", 64'(bus.sent_count), 8);
      repeat (15) @(posedge clk);
      ack_delay[3] = 0;

      // Destination boundary: 15 is legal, 16 and 23 are dropped, then a local flit.
      d0 = drops;
      push(8'h0f);
      push(8'h10);
      push(8'h37);
      push(8'h05);
      drain(80);
      check("t5_drops", 64'(drops - d0), 2);
      check("t5_sent", 64'(bus.sent_count), 10);
      check("t5_drop_low", 64'(bus.drop_pulse), 0);

      // Asynchronous reset while east is busy and a flit is held.
      ack_delay[3] = 40;
      push(8'h27);
      push(8'h26);
      wait_launch(11, 40);
      repeat (4) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("t6_tx_req", 64'(bus.tx_req), 0);
      check("t6_tx_data", 64'(bus.tx_data), 0);
      check("t6_sent", 64'(bus.sent_count), 0);
      check("t6_drop", 64'(bus.drop_pulse), 0);
      check("t6_fifo_read", 64'(bus.fifo_read), 0);
      src_q.delete();
      exp_q.delete();
      read_cyc_q.delete();
      launches = 0;
      bus.tx_ack = '0;
      bus.fifo_empty = 1'b1;
      for (int p = 0; p < 5; p++) begin
         wait_cnt[p]   = 0;
         model_data[p] = '0;
      end
      ack_delay[3] = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      check("t6_no_stale_launch", 64'(bus.tx_req), 0);
      push(8'h27);
      drain(50);
      check("t6_relaunch_req", 64'(bus.tx_req), 64'(5'b01000));
      check("t6_relaunch_sent", 64'(bus.sent_count), 1);

      // Randomized traffic: mixed legal/illegal destinations, random acks and FIFO gaps.
      rand_on = 1'b1;
      for (int b = 0; b < 15; b++) begin
         for (int p = 0; p < 5; p++) ack_delay[p] = $urandom_range(0, 4);
         for (int i = 0; i < 20; i++) begin
            logic [7:0] f;
            f      = 8'($urandom_range(0, 255));
            f[4:0] = 5'($urandom_range(0, 31));
            push(f);
         end
         repeat ($urandom_range(5, 60)) @(posedge clk);
      end
      rand_on = 1'b0;
      drain(6000);
      check("rand_sent", 64'(bus.sent_count), 64'(launches & 16'hffff));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
